// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encodings, register
// addresses and the interrupt source index map.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [15:0] ADDR_MASK_DEF = 16'hFFF4;
  localparam logic [15:0] ADDR_PEND_DEF = 16'hFFF6;

  // Source index map; index 0 has the highest priority.
  localparam int SRC_TIMER = 0;
  localparam int SRC_KEY1  = 1;
  localparam int SRC_KEY2  = 2;
  localparam int SRC_KEY3  = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit plus an any-valid flag.
module irq_prio_enc #(
  parameter int NSRC   = 4,
  parameter int IDBITS = 4
) (
  input  logic [NSRC-1:0]   req_i,
  output logic [IDBITS-1:0] id_o,
  output logic              valid_o
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    id_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IDBITS'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt pending/mask registers with edge detection, fixed-priority
// arbitration and the req/ack/reti handshake towards the CPU pipeline.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int               DBITS     = 16,
  parameter int               NSRC      = 4,
  parameter int               IDBITS    = 4,
  parameter logic [DBITS-1:0] ADDR_MASK = ADDR_MASK_DEF,
  parameter logic [DBITS-1:0] ADDR_PEND = ADDR_PEND_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   src_lvl,
  input  logic              ie,
  input  logic [DBITS-1:0]  bus_addr,
  input  logic              bus_we,
  input  logic [DBITS-1:0]  bus_wdata,
  output logic [DBITS-1:0]  bus_rdata,
  output logic              bus_hit,
  output logic              irq_req,
  output logic [IDBITS-1:0] irq_id,
  input  logic              irq_ack,
  input  logic              reti,
  output logic              in_service
);

  irq_state_e        state_q;
  logic [NSRC-1:0]   mask_q, pend_q, pend_d, src_prev_q;
  logic [NSRC-1:0]   rise, eligible, id_onehot, w1c_clr, ack_clr;
  logic [IDBITS-1:0] irq_id_q, grant_id;
  logic              irq_req_q, in_service_q, grant_valid;
  logic              hit_mask, hit_pend, ack_take, id_still_eligible;

  assign hit_mask = (bus_addr == ADDR_MASK);
  assign hit_pend = (bus_addr == ADDR_PEND);
  assign bus_hit  = hit_mask | hit_pend;

  always_comb begin
    bus_rdata = '0;
    if (hit_mask)      bus_rdata[NSRC-1:0] = mask_q;
    else if (hit_pend) bus_rdata[NSRC-1:0] = pend_q;
  end

  generate
    if (NSRC < DBITS) begin : g_unused_wdata
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^bus_wdata[DBITS-1:NSRC];
    end
  endgenerate

  assign rise      = src_lvl & ~src_prev_q;
  assign eligible  = pend_q & mask_q;
  assign id_onehot = NSRC'(1) << irq_id_q;
  assign ack_take  = (state_q == ST_REQ) && irq_ack;
  assign ack_clr   = ack_take ? id_onehot : '0;
  assign w1c_clr   = (bus_we && hit_pend) ? bus_wdata[NSRC-1:0] : '0;
  // A fresh rise beats any clear of the same bit in the same cycle.
  assign pend_d    = (pend_q & ~(w1c_clr | ack_clr)) | rise;
  assign id_still_eligible = |(eligible & id_onehot);

  irq_prio_enc #(
    .NSRC   (NSRC),
    .IDBITS (IDBITS)
  ) u_prio_enc (
    .req_i   (eligible),
    .id_o    (grant_id),
    .valid_o (grant_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
    end else begin
      src_prev_q <= src_lvl;
      pend_q     <= pend_d;
      if (bus_we && hit_mask) mask_q <= bus_wdata[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      irq_req_q    <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ie && grant_valid) begin
            state_q   <= ST_REQ;
            irq_req_q <= 1'b1;
            irq_id_q  <= grant_id;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state_q      <= ST_SERVICE;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!ie || !id_still_eligible) begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (reti) begin
            state_q      <= ST_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          irq_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed test of irq_sequencer: edge capture, priority, W1C, ack/withdraw
// races and asynchronous reset in the middle of a handshake.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_lvl;
  logic        ie;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_hit;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic        irq_ack;
  logic        reti;
  logic        in_service;

  int n_compared   = 0;
  int n_mismatched = 0;

  irq_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_lvl    (src_lvl),
    .ie         (ie),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_hit    (bus_hit),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .reti       (reti),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic bus_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    bus_addr = addr;
    #1;
    check_val(tag, {16'h0, bus_rdata}, {16'h0, exp});
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; src_lvl = '0; ie = 1'b0; bus_addr = 16'h0; bus_we = 1'b0;
    bus_wdata = '0; irq_ack = 1'b0; reti = 1'b0;
    #12;
    check_val("rst_irq_req", 32'(irq_req), 32'd0);
    check_val("rst_irq_id", 32'(irq_id), 32'd0);
    check_val("rst_in_service", 32'(in_service), 32'd0);
    bus_check("rst_mask", 16'hFFF4, 16'h0000);
    check_val("hit_mask_addr", 32'(bus_hit), 32'd1);
    bus_addr = 16'hFFF0; #1;
    check_val("hit_key_addr", 32'(bus_hit), 32'd0);
    check_val("rdata_key_addr", 32'(bus_rdata), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: masked-in rise on source 2
    bus_write(16'hFFF4, 16'h0006);
    bus_check("t1_mask", 16'hFFF4, 16'h0006);
    ie = 1'b1;
    src_lvl = 4'b0100;
    tick();
    bus_check("t1_pend", 16'hFFF6, 16'h0004);
    check_val("t1_req_lat1", 32'(irq_req), 32'd0);
    tick();
    check_val("t1_req", 32'(irq_req), 32'd1);
    check_val("t1_id", 32'(irq_id), 32'd2);
    pulse_ack();
    check_val("t1_in_service", 32'(in_service), 32'd1);
    check_val("t1_req_drop", 32'(irq_req), 32'd0);
    bus_check("t1_pend_clr", 16'hFFF6, 16'h0000);
    pulse_reti();
    check_val("t1_reti", 32'(in_service), 32'd0);
    tick();
    bus_check("t1_level_once", 16'hFFF6, 16'h0000);
    check_val("t1_no_rereq", 32'(irq_req), 32'd0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check_val("t1_ack_idle_ignored", 32'(in_service), 32'd0);
    src_lvl = 4'b0000;
    tick();

    // 2: simultaneous rises on 1 and 3, lower index first
    bus_write(16'hFFF4, 16'h000F);
    src_lvl = 4'b1010;
    tick();
    tick();
    check_val("t2_req", 32'(irq_req), 32'd1);
    check_val("t2_id1", 32'(irq_id), 32'd1);
    pulse_ack();
    bus_check("t2_pend_after_ack", 16'hFFF6, 16'h0008);
    pulse_reti();
    tick();
    check_val("t2_req2", 32'(irq_req), 32'd1);
    check_val("t2_id3", 32'(irq_id), 32'd3);
    pulse_ack();
    pulse_reti();
    src_lvl = 4'b0000;
    tick();

    // 3: W1C withdraws an outstanding request
    src_lvl = 4'b0100;
    tick();
    tick();
    check_val("t3_req", 32'(irq_req), 32'd1);
    check_val("t3_id", 32'(irq_id), 32'd2);
    bus_write(16'hFFF6, 16'h0004);
    tick();
    check_val("t3_withdrawn", 32'(irq_req), 32'd0);
    tick();
    check_val("t3_stays_idle", 32'(irq_req), 32'd0);
    check_val("t3_not_service", 32'(in_service), 32'd0);
    src_lvl = 4'b0000;
    tick();

    // 4: ack and ie drop together, ack wins
    src_lvl = 4'b0001;
    tick();
    tick();
    check_val("t4_id", 32'(irq_id), 32'd0);
    ie = 1'b0;
    pulse_ack();
    check_val("t4_in_service", 32'(in_service), 32'd1);
    bus_check("t4_pend_clr", 16'hFFF6, 16'h0000);
    pulse_reti();
    check_val("t4_reti", 32'(in_service), 32'd0);
    ie = 1'b1;
    src_lvl = 4'b0000;
    tick();

    // 5: W1C collides with a new rise on the same bit
    bus_write(16'hFFF4, 16'h0000);
    src_lvl = 4'b0001;
    tick();
    src_lvl = 4'b0000;
    tick();
    src_lvl = 4'b0001;
    bus_write(16'hFFF6, 16'h0001);
    bus_check("t5_set_wins", 16'hFFF6, 16'h0001);
    bus_write(16'hFFF6, 16'h0001);
    bus_check("t5_w1c_clears", 16'hFFF6, 16'h0000);
    src_lvl = 4'b0000;
    tick();

    // 6: async reset during SERVICE
    bus_write(16'hFFF4, 16'h000F);
    src_lvl = 4'b0100;
    tick();
    tick();
    pulse_ack();
    check_val("t6_in_service", 32'(in_service), 32'd1);
    src_lvl = 4'b1000;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_req", 32'(irq_req), 32'd0);
    check_val("t6_rst_in_service", 32'(in_service), 32'd0);
    bus_check("t6_rst_mask", 16'hFFF4, 16'h0000);
    bus_check("t6_rst_pend", 16'hFFF6, 16'h0000);
    src_lvl = 4'b0000;
    #1;
    rst_n = 1'b1;
    tick();
    pulse_reti();
    check_val("t6_reti_ignored_svc", 32'(in_service), 32'd0);
    check_val("t6_reti_ignored_req", 32'(irq_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
